// File: rtl/pid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pid_pkg                                                        |
// | Purpose   : Shared definitions for the ADC -> PID sample path: default     |
// |             sample/channel/FIFO sizes, router FSM state encoding and the   |
// |             {chan, sample} FIFO entry layout.                              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package pid_pkg;

   localparam int W_IN_DEF       = 18;
   localparam int N_CHAN_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 16;
   localparam int W_CHAN_DEF     = $clog2(N_CHAN_DEF);

   // Router sequencing: a captured A/B pair is written as A then B.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PUSH_A = 2'd1,
      PUSH_B = 2'd2
   } router_state_e;

   // FIFO entry layout for the default build: channel index in the MSBs.
   typedef struct packed {
      logic [W_CHAN_DEF-1:0]      chan;
      logic signed [W_IN_DEF-1:0] sample;
   } fifo_entry_t;

endpackage : pid_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sync_fifo                                                      |
// | Purpose   : Single-clock first-word fall-through FIFO. The head entry is   |
// |             presented on rdata_out whenever empty_out is low.              |
// | Ports     : clk_in, n_reset_in (async, active low)                         |
// |             push_in/wdata_in  - write request (ignored when full)          |
// |             pop_in            - read request (ignored when empty)          |
// |             rdata_out         - head entry, zero when empty                |
// |             full_out, empty_out, level_out (occupancy, extra bit)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_in,
   input  logic             n_reset_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] wdata_in,
   input  logic             pop_in,
   output logic [WIDTH-1:0] rdata_out,
   output logic             full_out,
   output logic             empty_out,
   output logic [AW:0]      level_out
);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra bit so full and empty are distinguishable.
   always_comb begin
      level_out = wr_ptr_q - rd_ptr_q;
      full_out  = (level_out == (AW+1)'(DEPTH));
      empty_out = (level_out == '0);
      // Full is judged on the pre-pop occupancy: a push at full is refused
      // even if a pop happens in the same cycle.
      do_push   = push_in & ~full_out;
      do_pop    = pop_in & ~empty_out;
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
      rdata_out = empty_out ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only observable once written.
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_in;
      end
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/adc_sample_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : adc_sample_router                                              |
// | Purpose   : Captures the A/B sample words on each ADC data-valid strobe,   |
// |             serialises the pair and queues {channel, sample} in a FWFT     |
// |             FIFO towards the PID core. Applies a channel-enable mask       |
// |             latched on update_in rising edges and pulses overflow_out for  |
// |             every sample lost to backpressure or a colliding strobe.       |
// | Ports     : clk_in, n_reset_in (async, active low)                         |
// |             data_valid_in[N_CHAN], data_a_in, data_b_in - ADC capture side |
// |             update_in, chan_en_in[N_CHAN]              - front panel       |
// |             data_out, chan_out, data_valid_out, data_ready_in - stream     |
// |             fifo_level_out, overflow_out               - status            |
// |             drop_count_out[16] (only with ROUTER_DROP_CNT_EN defined)      |
// | Config    : `define ROUTER_DROP_CNT_EN adds the saturating drop counter.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module adc_sample_router
   import pid_pkg::*;
#(
   parameter int W_IN       = W_IN_DEF,
   parameter int N_CHAN     = N_CHAN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int W_CHAN    = $clog2(N_CHAN),
   localparam int W_LVL     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk_in,
   input  logic                     n_reset_in,
   input  logic [N_CHAN-1:0]        data_valid_in,
   input  logic signed [W_IN-1:0]   data_a_in,
   input  logic signed [W_IN-1:0]   data_b_in,
   input  logic                     update_in,
   input  logic [N_CHAN-1:0]        chan_en_in,
   output logic signed [W_IN-1:0]   data_out,
   output logic [W_CHAN-1:0]        chan_out,
   output logic                     data_valid_out,
   input  logic                     data_ready_in,
   output logic [W_LVL-1:0]         fifo_level_out,
   output logic                     overflow_out
`ifdef ROUTER_DROP_CNT_EN
   ,
   output logic [15:0]              drop_count_out
`endif
);

   localparam int N_HALF = N_CHAN / 2;
   localparam int W_ENT  = W_CHAN + W_IN;

   router_state_e            state_q, state_d;
   logic signed [W_IN-1:0]   hold_a_q, hold_a_d;
   logic signed [W_IN-1:0]   hold_b_q, hold_b_d;
   logic [W_CHAN-1:0]        idx_q, idx_d;
   logic [N_CHAN-1:0]        mask_q, mask_d;
   logic                     update_q, update_d;
   logic                     overflow_q, overflow_d;

   logic                     strobe;
   logic [W_CHAN-1:0]        strobe_idx;
   logic                     update_rise;
   logic                     push_req;
   logic [W_CHAN-1:0]        push_chan;
   logic signed [W_IN-1:0]   push_data;
   logic                     push_en;
   logic                     full_drop;
   logic                     strobe_drop;
   logic                     fifo_push;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [W_ENT-1:0]         fifo_rdata;
   logic [W_LVL-1:0]         fifo_level;

   // The upper half of the strobe mirrors the lower half (port B side of the
   // same conversion), so only the lower half drives capture.
   logic                     unused_upper_valid;
   assign unused_upper_valid = ^data_valid_in[N_CHAN-1:N_HALF];

   // Strobe detection and lowest-set-bit channel index of the lower half.
   always_comb begin
      strobe     = |data_valid_in[N_HALF-1:0];
      strobe_idx = '0;
      for (int i = N_HALF - 1; i >= 0; i--) begin
         if (data_valid_in[i]) begin
            strobe_idx = W_CHAN'(i);
         end
      end
   end

   // Front-panel mask: registered edge detect, new mask used from the next cycle.
   always_comb begin
      update_d    = update_in;
      update_rise = update_in & ~update_q;
      mask_d      = update_rise ? chan_en_in : mask_q;
   end

   // Pair sequencer: next state, capture and write request.
   always_comb begin
      state_d     = state_q;
      hold_a_d    = hold_a_q;
      hold_b_d    = hold_b_q;
      idx_d       = idx_q;
      push_req    = 1'b0;
      push_chan   = idx_q;
      push_data   = hold_a_q;
      strobe_drop = 1'b0;

      case (state_q)
         IDLE: begin
            if (strobe) begin
               state_d = PUSH_A;
            end
         end
         PUSH_A: begin
            push_req  = 1'b1;
            push_chan = idx_q;
            push_data = hold_a_q;
            state_d   = PUSH_B;
            // Capture registers still hold the B word of this pair, so a new
            // strobe here cannot be taken.
            strobe_drop = strobe;
         end
         PUSH_B: begin
            push_req  = 1'b1;
            push_chan = idx_q + W_CHAN'(N_HALF);
            push_data = hold_b_q;
            state_d   = strobe ? PUSH_A : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new pair may overwrite the holds in the same edge that B is written.
      if (strobe && (state_q != PUSH_A)) begin
         hold_a_d = data_a_in;
         hold_b_d = data_b_in;
         idx_d    = strobe_idx;
      end
   end

   // Disabled channels are silently skipped; enabled ones drop only when full.
   always_comb begin
      push_en    = push_req & mask_q[push_chan];
      fifo_push  = push_en & ~fifo_full;
      full_drop  = push_en & fifo_full;
      overflow_d = full_drop | strobe_drop;
   end

   always_ff @(posedge clk_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         state_q    <= IDLE;
         hold_a_q   <= '0;
         hold_b_q   <= '0;
         idx_q      <= '0;
         mask_q     <= '1;
         update_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_a_q   <= hold_a_d;
         hold_b_q   <= hold_b_d;
         idx_q      <= idx_d;
         mask_q     <= mask_d;
         update_q   <= update_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (W_ENT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in     (clk_in),
      .n_reset_in (n_reset_in),
      .push_in    (fifo_push),
      .wdata_in   ({push_chan, push_data}),
      .pop_in     (data_ready_in),
      .rdata_out  (fifo_rdata),
      .full_out   (fifo_full),
      .empty_out  (fifo_empty),
      .level_out  (fifo_level)
   );

   always_comb begin
      chan_out       = fifo_rdata[W_ENT-1:W_IN];
      data_out       = fifo_rdata[W_IN-1:0];
      data_valid_out = ~fifo_empty;
      fifo_level_out = fifo_level;
      overflow_out   = overflow_q;
   end

`ifdef ROUTER_DROP_CNT_EN
   // A PUSH_A cycle can lose both a colliding strobe and a full-FIFO write,
   // so the increment is 0..2.
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_cnt_q} + {15'd0, full_drop} + {15'd0, strobe_drop};
      if (update_rise) begin
         drop_cnt_d = '0;
      end else if (drop_sum[16]) begin
         drop_cnt_d = 16'hFFFF;
      end else begin
         drop_cnt_d = drop_sum[15:0];
      end
   end

   always_ff @(posedge clk_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count_out = drop_cnt_q;
`else
   // Drop tally not built; overflow_out alone reports lost samples.
`endif

endmodule : adc_sample_router
`default_nettype wire

// File: tb/tb_adc_sample_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_adc_sample_router                                           |
// | Purpose   : Self-checking bench for adc_sample_router. A transaction-level |
// |             model (expected-entry queue plus pending A/B writes) predicts  |
// |             the stream, level and overflow every cycle. Directed pair      |
// |             scenarios are followed by randomized traffic phases.           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_adc_sample_router;

   localparam int W_IN   = 18;
   localparam int N_CHAN = 8;
   localparam int DEPTH  = 16;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [7:0]  dv;
   logic [17:0] a_in, b_in;
   logic        upd;
   logic [7:0]  en;
   logic        rdy;
   logic [17:0] data_out;
   logic [2:0]  chan_out;
   logic        valid_out;
   logic [4:0]  level_out;
   logic        ovf_out;
`ifdef ROUTER_DROP_CNT_EN
   logic [15:0] drop_cnt_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adc_sample_router #(
      .W_IN       (W_IN),
      .N_CHAN     (N_CHAN),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_in         (clk),
      .n_reset_in     (n_reset),
      .data_valid_in  (dv),
      .data_a_in      (a_in),
      .data_b_in      (b_in),
      .update_in      (upd),
      .chan_en_in     (en),
      .data_out       (data_out),
      .chan_out       (chan_out),
      .data_valid_out (valid_out),
      .data_ready_in  (rdy),
      .fifo_level_out (level_out),
      .overflow_out   (ovf_out)
`ifdef ROUTER_DROP_CNT_EN
      ,
      .drop_count_out (drop_cnt_out)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [2:0]  ch;
      logic [17:0] d;
   } ent_t;

   ent_t       q[$];          // entries the PID core should see, in order
   bit         pa_v, pb_v;    // a write of A / B is due at the next edge
   ent_t       pa_e, pa_b_e, pb_e;
   logic [7:0] m_mask;
   bit         m_upd_prev;
   int         m_cnt;
   bit         exp_ovf;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pa_v       = 0;
      pb_v       = 0;
      m_mask     = 8'hFF;
      m_upd_prev = 0;
      m_cnt      = 0;
      exp_ovf    = 0;
   endtask

   // Effect of one clock edge given the inputs that were applied before it.
   task automatic model_edge();
      int   n0;
      int   drops;
      bit   try_w, do_w, new_v;
      ent_t we, na, nb;
      int   idx;
      n0    = q.size();
      drops = 0;
      try_w = 0;
      do_w  = 0;
      new_v = 0;
      we    = '0;
      na    = '0;
      nb    = '0;
      if (pa_v) begin
         we = pa_e; try_w = 1;
      end else if (pb_v) begin
         we = pb_e; try_w = 1;
      end
      if (try_w && m_mask[we.ch]) begin
         if (n0 == DEPTH) drops++;
         else do_w = 1;
      end
      if (rdy && n0 > 0) void'(q.pop_front());
      if (do_w) q.push_back(we);
      if (|dv[3:0]) begin
         if (pa_v) begin
            drops++;
         end else begin
            idx = 0;
            for (int i = 3; i >= 0; i--) if (dv[i]) idx = i;
            new_v = 1;
            na = '{ch: 3'(idx),     d: a_in};
            nb = '{ch: 3'(idx + 4), d: b_in};
         end
      end
      pb_v = pa_v;
      pb_e = pa_b_e;
      pa_v = new_v;
      if (new_v) begin
         pa_e   = na;
         pa_b_e = nb;
      end
      exp_ovf = (drops > 0);
      if (upd && !m_upd_prev) begin
         m_mask = en;
         m_cnt  = 0;
      end else begin
         m_cnt = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
      end
      m_upd_prev = upd;
   endtask

   task automatic check_outputs();
      logic [31:0] e_d, e_c;
      e_d = (q.size() != 0) ? 32'(q[0].d)  : 32'd0;
      e_c = (q.size() != 0) ? 32'(q[0].ch) : 32'd0;
      check_eq("valid", 32'(valid_out), 32'(q.size() != 0));
      check_eq("level", 32'(level_out), 32'(q.size()));
      check_eq("overflow", 32'(ovf_out), 32'(exp_ovf));
      check_eq("data", 32'(data_out), e_d);
      check_eq("chan", 32'(chan_out), e_c);
`ifdef ROUTER_DROP_CNT_EN
      check_eq("drop_count", 32'(drop_cnt_out), 32'(m_cnt));
`endif
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_valid"}, 32'(valid_out), 32'd0);
      check_eq({tag, "_level"}, 32'(level_out), 32'd0);
      check_eq({tag, "_ovf"},   32'(ovf_out),   32'd0);
      check_eq({tag, "_data"},  32'(data_out),  32'd0);
      check_eq({tag, "_chan"},  32'(chan_out),  32'd0);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_pair(input int idx);
      dv       = '0;
      dv[idx]  = 1'b1;
      dv[idx+4] = 1'b1;
   endtask

   task automatic pair(input int idx, input logic [17:0] av, input logic [17:0] bv);
      set_pair(idx);
      a_in = av;
      b_in = bv;
      step();
      dv = '0;
   endtask

   task automatic idle(input int n);
      dv = '0;
      repeat (n) step();
   endtask

   task automatic pulse_update(input logic [7:0] m);
      en  = m;
      upd = 1'b1;
      step();
      upd = 1'b0;
      step();
   endtask

   task automatic rand_pair();
      set_pair($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dv[$urandom_range(0, 3)] = 1'b1;
      a_in = 18'($urandom);
      b_in = 18'($urandom);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p_strobe[6] = '{20, 50, 90, 100, 30, 70};
      int p_rdy[6]    = '{100, 50, 20, 100, 0, 90};

      n_reset = 1'b0;
      dv = '0; a_in = '0; b_in = '0; upd = 1'b0; en = 8'hFF; rdy = 1'b1;
      model_reset();

      // Strobes while held in reset must produce nothing.
      repeat (3) begin
         @(negedge clk);
         rand_pair();
         @(posedge clk);
         @(negedge clk);
         check_zero("reset");
      end
      n_reset = 1'b1;
      dv = '0;
      idle(2);

      // Mask resets to all ones: the highest channel pair is forwarded.
      pair(3, 18'h00ABC, 18'h3FF00);
      idle(4);

      // Single pair, immediate drain.
      rdy = 1'b1;
      pair(0, 18'h10001, 18'h3FFFB);
      idle(4);

      // Four spaced pairs accumulate in order, then drain.
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pair(i, 18'($urandom), 18'($urandom));
         idle(17);
      end
      rdy = 1'b1;
      idle(10);

      // Mask only the lower half: only the A channel is queued.
      pulse_update(8'h0F);
      idle(2);
      pair(1, 18'h12345, 18'h2AAAA);
      idle(4);
      pulse_update(8'hFF);
      idle(2);

      // Backpressure: fill, overflow a whole pair, then push-at-full with pop.
      rdy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         pair(k % 4, 18'($urandom), 18'($urandom));
         idle(2);
      end
      pair(2, 18'h00111, 18'h00222);
      idle(3);
      set_pair(1);
      a_in = 18'h00333; b_in = 18'h00444;
      step();
      dv  = '0;
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      idle(3);
      rdy = 1'b1;
      idle(20);

      // Back-to-back strobes: second collides with PUSH_A, third lands in PUSH_B.
      for (int k = 0; k < 3; k++) begin
         set_pair(k);
         a_in = 18'($urandom);
         b_in = 18'($urandom);
         step();
      end
      idle(6);

      // Asynchronous reset in the middle of a pair.
      rdy = 1'b0;
      pair(2, 18'h01010, 18'h02020);
      step();
      #2;
      n_reset = 1'b0;
      #1;
      model_reset();
      check_zero("async_reset");
      @(negedge clk);
      check_zero("async_hold");
      n_reset = 1'b1;
      rdy = 1'b1;
      idle(4);

      // Randomized traffic phases.
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 99) < p_strobe[p]) rand_pair();
            else dv = '0;
            rdy = ($urandom_range(0, 99) < p_rdy[p]);
            upd = ($urandom_range(0, 149) == 0);
            if (upd) en = 8'($urandom) | 8'h11;
            step();
         end
      end
      upd = 1'b0;
      rdy = 1'b1;
      idle(24);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_adc_sample_router
`default_nettype wire
